// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit.
// Takes the decoded memory control word, issues one word-aligned, byte-enabled
// request to data memory, waits for mem_ack (bounded by TIMEOUT cycles) and
// returns sign/zero-extended load data. stall freezes the pipeline while the
// request is outstanding.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      launch an access (sampled only in IDLE)
//   MemReg, memWritte          load / store request (store has priority)
//   MemReadByte, MemWriteByte  size masks: 0001 byte, 0011 half, 1111 word
//   LoadUnsigned               1 = zero-extend loads
//   AluResult, WriteData       byte address, store data
//   mem_req/we/addr/be/wdata   memory request
//   mem_rdata, mem_ack         memory response
//   stall, done                pipeline freeze, one-cycle completion pulse
//   ReadData                   extended load result
//   addr_err, timeout_err      error flags, valid only while done = 1
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        MemReg,
    input  logic        memWritte,
    input  logic [3:0]  MemReadByte,
    input  logic [3:0]  MemWriteByte,
    input  logic        LoadUnsigned,
    input  logic [31:0] AluResult,
    input  logic [31:0] WriteData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        done,
    output logic [31:0] ReadData,
    output logic        addr_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {StIdle = 2'd0, StAccess = 2'd1, StResp = 2'd2} state_e;

    localparam logic [1:0] SzByte = 2'd0;
    localparam logic [1:0] SzHalf = 2'd1;
    localparam logic [1:0] SzWord = 2'd2;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aerr_q, aerr_d;
    logic        terr_q, terr_d;

    // Request decode from the live inputs; only used when start is taken in IDLE.
    logic [3:0]  req_mask;
    logic        is_byte, is_half, is_word, bad_req;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    always_comb begin
        req_mask = memWritte ? MemWriteByte : MemReadByte;
        is_byte  = (req_mask == 4'b0001);
        is_half  = (req_mask == 4'b0011);
        is_word  = (req_mask == 4'b1111);
        bad_req  = !(is_byte || is_half || is_word)
                   || (is_half && AluResult[0])
                   || (is_word && (AluResult[1:0] != 2'b00));
        if (is_byte) begin
            req_be    = 4'b0001 << AluResult[1:0];
            req_wdata = {4{WriteData[7:0]}};
        end else if (is_half) begin
            req_be    = AluResult[1] ? 4'b1100 : 4'b0011;
            req_wdata = {2{WriteData[15:0]}};
        end else begin
            req_be    = 4'b1111;
            req_wdata = WriteData;
        end
    end

    // Lane extraction and extension of the returning load data.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    always_comb begin
        ld_byte  = mem_rdata[{lane_q, 3'b000} +: 8];
        ld_half  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext = mem_rdata;
        unique case (size_q)
            SzByte:  load_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            SzHalf:  load_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        lane_d  = lane_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        aerr_d  = aerr_q;
        terr_d  = terr_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    we_d    = memWritte;
                    addr_d  = {AluResult[31:2], 2'b00};
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    lane_d  = AluResult[1:0];
                    size_d  = is_byte ? SzByte : (is_half ? SzHalf : SzWord);
                    uns_d   = LoadUnsigned;
                    aerr_d  = 1'b0;
                    terr_d  = 1'b0;
                    if (!MemReg && !memWritte) begin
                        state_d = StResp;
                        rdata_d = 32'd0;
                    end else if (bad_req) begin
                        state_d = StResp;
                        aerr_d  = 1'b1;
                    end else begin
                        state_d = StAccess;
                        cnt_d   = 8'd0;
                    end
                end
            end
            StAccess: begin
                // Ack beats the timeout when both land in the same cycle.
                if (mem_ack) begin
                    if (!we_q) begin
                        rdata_d = load_ext;
                    end
                    state_d = StResp;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    rdata_d = 32'd0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            lane_q  <= 2'd0;
            size_q  <= SzByte;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
            aerr_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            aerr_q  <= aerr_d;
            terr_q  <= terr_d;
        end
    end

    assign mem_req     = (state_q == StAccess);
    assign stall       = (state_q == StAccess);
    assign mem_we      = (state_q == StAccess) && we_q;
    assign mem_addr    = addr_q;
    assign mem_be      = be_q;
    assign mem_wdata   = wdata_q;
    assign done        = (state_q == StResp);
    assign addr_err    = (state_q == StResp) && aerr_q;
    assign timeout_err = (state_q == StResp) && terr_q;
    assign ReadData    = rdata_q;

endmodule
